// File: rtl/axi_lite_reg_pkg.sv
// axi_lite_reg_pkg: shared constants, word map and FSM states for the D-PHY RX register slave
package axi_lite_reg_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int NUM_CTRL   = 4;
    localparam int NUM_STATUS = 4;
    localparam logic [2:0] IDX_CTRL_FIRST   = 3'd0;
    localparam logic [2:0] IDX_STATUS_FIRST = 3'd4;

    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    function automatic logic is_status(input logic [2:0] idx);
        return idx >= IDX_STATUS_FIRST;
    endfunction
endpackage

// File: rtl/axi_lite_wr_ctrl.sv
// axi_lite_wr_ctrl: AW/W capture, write FSM and B response; emits a commit pulse for the register bank
module axi_lite_wr_ctrl
    import axi_lite_reg_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [2:0]      i_aw_idx,
    input  logic            i_awvalid,
    output logic            o_awready,
    input  logic [DW-1:0]   i_wdata,
    input  logic [DW/8-1:0] i_wstrb,
    input  logic            i_wvalid,
    output logic            o_wready,
    output logic [1:0]      o_bresp,
    output logic            o_bvalid,
    input  logic            i_bready,
    output logic            o_commit,
    output logic [2:0]      o_commit_idx,
    output logic [DW-1:0]   o_commit_data,
    output logic [DW/8-1:0] o_commit_strb
);
    wr_state_t       r_state;
    wr_state_t       w_next;
    logic            r_awready;
    logic            r_wready;
    logic            r_have_aw;
    logic            r_have_w;
    logic [2:0]      r_idx;
    logic [DW-1:0]   r_data;
    logic [DW/8-1:0] r_strb;
    logic [1:0]      r_bresp;
    logic            w_aw_hs;
    logic            w_w_hs;
    logic            w_have_aw;
    logic            w_have_w;

    assign w_aw_hs       = i_awvalid & r_awready;
    assign w_w_hs        = i_wvalid & r_wready;
    assign w_have_aw     = r_have_aw | w_aw_hs;
    assign w_have_w      = r_have_w | w_w_hs;
    assign o_commit      = (r_state != W_RESP) && w_have_aw && w_have_w;
    assign o_commit_idx  = w_aw_hs ? i_aw_idx : r_idx;
    assign o_commit_data = w_w_hs ? i_wdata : r_data;
    assign o_commit_strb = w_w_hs ? i_wstrb : r_strb;
    assign o_awready     = r_awready;
    assign o_wready      = r_wready;
    assign o_bvalid      = r_state == W_RESP;
    assign o_bresp       = r_bresp;

    // Next state: commit once both halves are present, otherwise park in W_WAIT with what arrived
    always_comb begin
        w_next = r_state;
        case (r_state)
            W_IDLE, W_WAIT: w_next = o_commit ? W_RESP : (w_have_aw || w_have_w) ? W_WAIT : r_state;
            W_RESP:         w_next = i_bready ? W_IDLE : W_RESP;
            default:        w_next = W_IDLE;
        endcase
    end

    // State register; READYs are registered so they rise on the first edge out of reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_have_aw <= 1'b0;
            r_have_w  <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_awready <= (w_next == W_IDLE) || (w_next == W_WAIT && !w_have_aw);
            r_wready  <= (w_next == W_IDLE) || (w_next == W_WAIT && !w_have_w);
            r_have_aw <= (w_next == W_WAIT) && w_have_aw;
            r_have_w  <= (w_next == W_WAIT) && w_have_w;
        end
    end

    // Holding registers for a half-arrived write and the response code of the committed one
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_idx   <= '0;
            r_data  <= '0;
            r_strb  <= '0;
            r_bresp <= RESP_OKAY;
        end else begin
            if (w_aw_hs) r_idx <= i_aw_idx;
            if (w_w_hs) begin
                r_data <= i_wdata;
                r_strb <= i_wstrb;
            end
            if (o_commit) r_bresp <= is_status(o_commit_idx) ? RESP_SLVERR : RESP_OKAY;
        end
    end
endmodule

// File: rtl/axi_lite_reg_slave.sv
// axi_lite_reg_slave: AXI4-Lite register bank with four control and four status words
module axi_lite_reg_slave
    import axi_lite_reg_pkg::*;
#(
    parameter int           C_S_AXI_LITE_DATA_WIDTH = 32,
    parameter int           C_S_AXI_LITE_ADDR_WIDTH = 5,
    parameter logic [127:0] C_CTRL_RESET            = 128'h0
) (
    input  logic                                      S_AXI_LITE_ACLK,
    input  logic                                      S_AXI_LITE_ARESET,
    input  logic [C_S_AXI_LITE_ADDR_WIDTH-1:0]        S_AXI_LITE_AWADDR,
    input  logic [2:0]                                S_AXI_LITE_AWPROT,
    input  logic                                      S_AXI_LITE_AWVALID,
    output logic                                      S_AXI_LITE_AWREADY,
    input  logic [C_S_AXI_LITE_DATA_WIDTH-1:0]        S_AXI_LITE_WDATA,
    input  logic [C_S_AXI_LITE_DATA_WIDTH/8-1:0]      S_AXI_LITE_WSTRB,
    input  logic                                      S_AXI_LITE_WVALID,
    output logic                                      S_AXI_LITE_WREADY,
    output logic [1:0]                                S_AXI_LITE_BRESP,
    output logic                                      S_AXI_LITE_BVALID,
    input  logic                                      S_AXI_LITE_BREADY,
    input  logic [C_S_AXI_LITE_ADDR_WIDTH-1:0]        S_AXI_LITE_ARADDR,
    input  logic [2:0]                                S_AXI_LITE_ARPROT,
    input  logic                                      S_AXI_LITE_ARVALID,
    output logic                                      S_AXI_LITE_ARREADY,
    output logic [C_S_AXI_LITE_DATA_WIDTH-1:0]        S_AXI_LITE_RDATA,
    output logic [1:0]                                S_AXI_LITE_RRESP,
    output logic                                      S_AXI_LITE_RVALID,
    input  logic                                      S_AXI_LITE_RREADY,
    output logic [NUM_CTRL*C_S_AXI_LITE_DATA_WIDTH-1:0]   ctrl_regs,
    output logic [NUM_CTRL-1:0]                           ctrl_wr_strobe,
    input  logic [NUM_STATUS*C_S_AXI_LITE_DATA_WIDTH-1:0] status_in
);
    localparam int DW = C_S_AXI_LITE_DATA_WIDTH;
    localparam int AW = C_S_AXI_LITE_ADDR_WIDTH;

    logic [NUM_CTRL-1:0][DW-1:0]   r_ctrl;
    logic [NUM_CTRL-1:0]           r_strobe;
    logic [NUM_STATUS-1:0][DW-1:0] w_status;
    rd_state_t                     r_rstate;
    rd_state_t                     w_rnext;
    logic                          r_arready;
    logic [DW-1:0]                 r_rdata;
    logic [2:0]                    w_ar_idx;
    logic                          w_ar_hs;
    logic                          w_commit;
    logic [2:0]                    w_cidx;
    logic [DW-1:0]                 w_cdata;
    logic [DW/8-1:0]               w_cstrb;
    logic                          w_unused;

    assign w_status           = status_in;
    assign w_ar_idx           = S_AXI_LITE_ARADDR[AW-1:2];
    assign w_ar_hs            = S_AXI_LITE_ARVALID & r_arready;
    assign ctrl_regs          = r_ctrl;
    assign ctrl_wr_strobe     = r_strobe;
    assign S_AXI_LITE_ARREADY = r_arready;
    assign S_AXI_LITE_RDATA   = r_rdata;
    assign S_AXI_LITE_RRESP   = RESP_OKAY;
    assign S_AXI_LITE_RVALID  = r_rstate == R_DATA;
    assign w_unused           = ^{S_AXI_LITE_AWPROT, S_AXI_LITE_ARPROT,
                                  S_AXI_LITE_AWADDR[1:0], S_AXI_LITE_ARADDR[1:0]};

    axi_lite_wr_ctrl #(.DW(DW)) u_wr_ctrl (
        .i_clk         (S_AXI_LITE_ACLK),
        .i_rst         (S_AXI_LITE_ARESET),
        .i_aw_idx      (S_AXI_LITE_AWADDR[AW-1:2]),
        .i_awvalid     (S_AXI_LITE_AWVALID),
        .o_awready     (S_AXI_LITE_AWREADY),
        .i_wdata       (S_AXI_LITE_WDATA),
        .i_wstrb       (S_AXI_LITE_WSTRB),
        .i_wvalid      (S_AXI_LITE_WVALID),
        .o_wready      (S_AXI_LITE_WREADY),
        .o_bresp       (S_AXI_LITE_BRESP),
        .o_bvalid      (S_AXI_LITE_BVALID),
        .i_bready      (S_AXI_LITE_BREADY),
        .o_commit      (w_commit),
        .o_commit_idx  (w_cidx),
        .o_commit_data (w_cdata),
        .o_commit_strb (w_cstrb)
    );

    // Control bank: byte-masked update on commit, status indices leave it untouched
    always_ff @(posedge S_AXI_LITE_ACLK) begin
        if (S_AXI_LITE_ARESET) begin
            r_ctrl   <= C_CTRL_RESET;
            r_strobe <= '0;
        end else begin
            r_strobe <= (w_commit && !is_status(w_cidx)) ? {{(NUM_CTRL-1){1'b0}}, 1'b1} << w_cidx[1:0] : '0;
            if (w_commit && !is_status(w_cidx))
                for (int b = 0; b < DW/8; b++)
                    if (w_cstrb[b]) r_ctrl[w_cidx[1:0]][b*8 +: 8] <= w_cdata[b*8 +: 8];
        end
    end

    // Read next state: capture on AR handshake, hold the beat until RREADY
    always_comb begin
        w_rnext = r_rstate;
        case (r_rstate)
            R_IDLE:  w_rnext = w_ar_hs ? R_DATA : R_IDLE;
            R_DATA:  w_rnext = S_AXI_LITE_RREADY ? R_IDLE : R_DATA;
            default: w_rnext = R_IDLE;
        endcase
    end

    // Read state register with ARREADY registered from the next state
    always_ff @(posedge S_AXI_LITE_ACLK) begin
        if (S_AXI_LITE_ARESET) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
        end else begin
            r_rstate  <= w_rnext;
            r_arready <= w_rnext == R_IDLE;
        end
    end

    // Read data capture; a same-edge commit is not yet visible, so the old word is returned
    always_ff @(posedge S_AXI_LITE_ACLK) begin
        if (S_AXI_LITE_ARESET) r_rdata <= '0;
        else if (w_ar_hs) r_rdata <= is_status(w_ar_idx) ? w_status[w_ar_idx[1:0]] : r_ctrl[w_ar_idx[1:0]];
    end
endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// tb_axi_lite_reg_slave: directed and randomized AXI4-Lite traffic checked against a word-level model
module tb_axi_lite_reg_slave;
    localparam logic [127:0] RST_VAL = 128'h33333333_22222222_11111111_00000000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [4:0]   awaddr = '0;
    logic [2:0]   awprot = '0;
    logic         awvalid = 1'b0;
    logic         awready;
    logic [31:0]  wdata = '0;
    logic [3:0]   wstrb = '0;
    logic         wvalid = 1'b0;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready = 1'b0;
    logic [4:0]   araddr = '0;
    logic [2:0]   arprot = '0;
    logic         arvalid = 1'b0;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready = 1'b0;
    logic [127:0] ctrl_regs;
    logic [3:0]   strobe;
    logic [127:0] status_in;

    logic [31:0]  m_ctrl [4];
    logic [31:0]  st [4];
    int           n_chk = 0;
    int           n_fail = 0;

    assign status_in = {st[3], st[2], st[1], st[0]};

    always #5 clk = ~clk;

    axi_lite_reg_slave #(.C_CTRL_RESET(RST_VAL)) dut (
        .S_AXI_LITE_ACLK    (clk),
        .S_AXI_LITE_ARESET  (rst),
        .S_AXI_LITE_AWADDR  (awaddr),
        .S_AXI_LITE_AWPROT  (awprot),
        .S_AXI_LITE_AWVALID (awvalid),
        .S_AXI_LITE_AWREADY (awready),
        .S_AXI_LITE_WDATA   (wdata),
        .S_AXI_LITE_WSTRB   (wstrb),
        .S_AXI_LITE_WVALID  (wvalid),
        .S_AXI_LITE_WREADY  (wready),
        .S_AXI_LITE_BRESP   (bresp),
        .S_AXI_LITE_BVALID  (bvalid),
        .S_AXI_LITE_BREADY  (bready),
        .S_AXI_LITE_ARADDR  (araddr),
        .S_AXI_LITE_ARPROT  (arprot),
        .S_AXI_LITE_ARVALID (arvalid),
        .S_AXI_LITE_ARREADY (arready),
        .S_AXI_LITE_RDATA   (rdata),
        .S_AXI_LITE_RRESP   (rresp),
        .S_AXI_LITE_RVALID  (rvalid),
        .S_AXI_LITE_RREADY  (rready),
        .ctrl_regs          (ctrl_regs),
        .ctrl_wr_strobe     (strobe),
        .status_in          (status_in)
    );

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] model_pack();
        return {m_ctrl[3], m_ctrl[2], m_ctrl[1], m_ctrl[0]};
    endfunction

    function automatic logic [31:0] exp_word(input logic [2:0] idx);
        return idx < 4 ? m_ctrl[idx[1:0]] : st[idx[1:0]];
    endfunction

    task automatic model_reset();
        logic [127:0] rv;
        rv = RST_VAL;
        for (int i = 0; i < 4; i++) m_ctrl[i] = rv[32*i +: 32];
    endtask

    task automatic do_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly);
        logic aw_done, w_done, aw_hs, w_hs;
        logic [2:0] idx;
        logic [1:0] eresp;
        logic [3:0] estb;
        int cyc;
        aw_done = 0; w_done = 0; cyc = 0; idx = addr[4:2];
        awaddr = addr; wdata = data; wstrb = strb; bready = 0;
        while (!(aw_done && w_done) && cyc < 40) begin
            awvalid = !aw_done && cyc >= aw_dly;
            wvalid  = !w_done && cyc >= w_dly;
            if (aw_done) chk("awready_low_in_wait", awready, 0);
            if (w_done) chk("wready_low_in_wait", wready, 0);
            aw_hs = awvalid & awready;
            w_hs  = wvalid & wready;
            @(posedge clk); #1;
            aw_done |= aw_hs;
            w_done  |= w_hs;
            cyc++;
        end
        awvalid = 0; wvalid = 0;
        chk("wr_handshakes", {aw_done, w_done}, 2'b11);
        if (idx < 4)
            for (int b = 0; b < 4; b++) if (strb[b]) m_ctrl[idx[1:0]][b*8 +: 8] = data[b*8 +: 8];
        eresp = idx >= 4 ? 2'b10 : 2'b00;
        estb  = idx >= 4 ? 4'b0000 : 4'b0001 << idx[1:0];
        chk("bvalid_after_commit", bvalid, 1);
        chk("bresp", bresp, eresp);
        chk("wr_strobe", strobe, estb);
        chk("ctrl_regs", ctrl_regs, model_pack());
        for (int i = 0; i < b_dly; i++) begin
            @(posedge clk); #1;
            chk("bvalid_stall", bvalid, 1);
            chk("bresp_stall", bresp, eresp);
            chk("awready_in_resp", {awready, wready}, 2'b00);
        end
        bready = 1;
        @(posedge clk); #1;
        bready = 0;
        chk("bvalid_cleared", bvalid, 0);
        chk("strobe_cleared", strobe, 0);
        chk("readys_after_b", {awready, wready}, 2'b11);
    endtask

    task automatic do_read(input logic [4:0] addr, input logic [31:0] exp, input int r_dly);
        logic done, hs;
        int cyc;
        done = 0; cyc = 0;
        araddr = addr; arvalid = 1; rready = 0;
        while (!done && cyc < 40) begin
            hs = arready;
            @(posedge clk); #1;
            done = hs;
            cyc++;
        end
        arvalid = 0;
        chk("ar_handshake", done, 1);
        chk("rvalid", rvalid, 1);
        chk("rdata", rdata, exp);
        chk("rresp", rresp, 2'b00);
        for (int i = 0; i < r_dly; i++) begin
            @(posedge clk); #1;
            chk("rvalid_stall", rvalid, 1);
            chk("rdata_stall", rdata, exp);
            chk("arready_stall", arready, 0);
        end
        rready = 1;
        @(posedge clk); #1;
        rready = 0;
        chk("rvalid_cleared", rvalid, 0);
        chk("arready_after_r", arready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] a;
        logic [31:0] d;
        for (int i = 0; i < 4; i++) st[i] = 32'h5000_0000 + i;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_readys", {awready, wready, arready}, 3'b000);
        chk("reset_valids", {bvalid, rvalid}, 2'b00);
        chk("reset_bresp_rresp_rdata", {bresp, rresp, rdata}, 0);
        chk("reset_strobe", strobe, 0);
        chk("reset_ctrl", ctrl_regs, RST_VAL);
        rst = 0;
        @(posedge clk); #1;
        chk("readys_after_reset", {awready, wready, arready}, 3'b111);

        do_write(5'h00, 32'h0101FFFF, 4'hF, 0, 0, 0);
        do_write(5'h04, 32'hABCD0001, 4'hF, 0, 0, 0);
        do_write(5'h08, 32'hDEAD0011, 4'hF, 0, 0, 0);
        do_write(5'h0C, 32'hBEEF0011, 4'hF, 0, 0, 0);
        for (int i = 0; i < 4; i++) do_read(5'(i * 4), exp_word(3'(i)), 0);

        do_write(5'h04, 32'h12345678, 4'b0101, 0, 3, 0);
        chk("t2_word1", ctrl_regs[63:32], 32'hAB340078);

        st[1] = 32'hCAFE0005;
        do_read(5'h14, 32'hCAFE0005, 0);
        do_write(5'h14, 32'hFFFFFFFF, 4'hF, 0, 0, 0);

        fork
            do_read(5'h08, exp_word(3'd2), 10);
            do_write(5'h00, 32'h5A5AA5A5, 4'hF, 0, 0, 0);
        join

        fork
            do_write(5'h0C, 32'h00000001, 4'hF, 0, 0, 0);
            do_read(5'h0C, 32'hBEEF0011, 0);
        join
        do_read(5'h0C, 32'h00000001, 0);

        awaddr = 5'h04; awvalid = 1;
        @(posedge clk); #1;
        awvalid = 0;
        chk("t5_wait_readys", {awready, wready}, 2'b01);
        rst = 1;
        @(posedge clk); #1;
        chk("t5_bvalid", bvalid, 0);
        chk("t5_ctrl", ctrl_regs, RST_VAL);
        chk("t5_readys", {awready, wready, arready}, 3'b000);
        rst = 0;
        model_reset();
        @(posedge clk); #1;
        chk("t5_readys_release", {awready, wready, arready}, 3'b111);
        do_write(5'h08, 32'h0BADF00D, 4'b1001, 1, 0, 0);

        for (int n = 0; n < 80; n++) begin
            st[$urandom_range(0, 3)] = $urandom;
            a = 5'($urandom_range(0, 31));
            d = $urandom;
            if ($urandom_range(0, 1) == 1)
                do_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 2));
            else
                do_read(a, exp_word(a[4:2]), $urandom_range(0, 2));
        end
        chk("final_ctrl", ctrl_regs, model_pack());

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_lite_reg_slave.md
Name: axi_lite_reg_slave

Overview:
AXI4-Lite responder that provides the register bank behind the S_AXI_LITE port of the MIPI D-PHY RX block. It is driven by the AXI4-Lite master BFM in our block-design benches and by the PS in hardware.
- Four read/write control words feed the PHY datapath.
- Four read-only status words are sampled from the PHY.
- Every AXI4-Lite channel carries a full VALID/READY handshake.
- Each control word raises a one-cycle write strobe when written.

Parameters:
- C_S_AXI_LITE_DATA_WIDTH, 32: data bus width. Only 32 is supported.
- C_S_AXI_LITE_ADDR_WIDTH, 5: byte address width, covering 8 words.
- C_CTRL_RESET, 128'h0: reset values of control words 3..0, packed with word 0 in bits [31:0].

Ports:
- S_AXI_LITE_ACLK  in  1  single clock for the whole block.
- S_AXI_LITE_ARESET  in  1  synchronous reset, active-high.
- S_AXI_LITE_AWADDR  in  5  write address.
- S_AXI_LITE_AWPROT  in  3  ignored.
- S_AXI_LITE_AWVALID  in  1
- S_AXI_LITE_AWREADY  out  1
- S_AXI_LITE_WDATA  in  32
- S_AXI_LITE_WSTRB  in  4  byte enables.
- S_AXI_LITE_WVALID  in  1
- S_AXI_LITE_WREADY  out  1
- S_AXI_LITE_BRESP  out  2
- S_AXI_LITE_BVALID  out  1
- S_AXI_LITE_BREADY  in  1
- S_AXI_LITE_ARADDR  in  5
- S_AXI_LITE_ARPROT  in  3  ignored.
- S_AXI_LITE_ARVALID  in  1
- S_AXI_LITE_ARREADY  out  1
- S_AXI_LITE_RDATA  out  32
- S_AXI_LITE_RRESP  out  2
- S_AXI_LITE_RVALID  out  1
- S_AXI_LITE_RREADY  in  1
- ctrl_regs  out  128  control words 0..3, word n in bits [32n+31:32n].
- ctrl_wr_strobe  out  4  one-cycle pulse per control word written.
- status_in  in  128  status words 4..7, packed the same way.

Behaviour:
Reset (S_AXI_LITE_ARESET high at a clock edge):
- All READY, BVALID and RVALID go to 0.
- BRESP, RRESP and RDATA go to 0; ctrl_wr_strobe goes to 0.
- ctrl_regs take C_CTRL_RESET.
- Holding registers are cleared. A transaction in flight is aborted with no response.
- On the first edge with reset low, AWREADY, WREADY and ARREADY register to 1.

Address decode:
- Word index is ADDR[4:2]; ADDR[1:0] and PROT are ignored.
- Indices 0-3 are control words. Indices 4-7 are status words.

Write FSM (W_IDLE, W_WAIT, W_RESP):
- W_IDLE: AWREADY=WREADY=1.
  - AW and W handshake in the same cycle T: the write commits at edge T+1, BVALID=1 from T+1, go to W_RESP.
  - Only one of AW/W handshakes: latch it, drop that channel's READY, go to W_WAIT.
- W_WAIT: waits for the missing channel, then commits the write and asserts BVALID on the next edge; go to W_RESP.
- W_RESP: AWREADY=WREADY=0. Hold BVALID and BRESP stable until BREADY. After the B handshake, return to W_IDLE and raise both READYs.

Write commit:
- Index 0-3: byte lane i updates only where WSTRB[i]=1. ctrl_wr_strobe[index] pulses for exactly the commit cycle, including when WSTRB=0. BRESP=OKAY (2'b00).
- Index 4-7: no state change, no strobe, BRESP=SLVERR (2'b10).

Read FSM (R_IDLE, R_DATA):
- R_IDLE: ARREADY=1. On an AR handshake at T, RDATA registers the addressed word at T+1 and RVALID=1. Status words are sampled at that edge. RRESP=OKAY for every index.
- R_DATA: ARREADY=0. RDATA, RRESP and RVALID stay stable until RREADY, then return to R_IDLE. ARREADY=1 the cycle after the R handshake.

Boundary rules:
- Read and write channels are independent and may be active concurrently.
- If a read capture and a write commit hit the same word at the same edge, the read returns the old value.
- Holding BREADY or RREADY low indefinitely stalls only its own channel.
- Back-to-back throughput: one write per 2 cycles with BREADY tied high, one read per 2 cycles.

Decomposition:
- Shared package axi_lite_reg_pkg holds:
  - RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10;
  - NUM_CTRL = 4 and NUM_STATUS = 4;
  - word index constants;
  - the write-FSM and read-FSM state enums.
- One sub-module is natural: axi_lite_wr_ctrl. It contains the AW/W capture, the write FSM and the B response, and outputs a commit pulse with index, data and strobe.
- The read path and the register bank stay in the top module.

Test Plan:
1. Reset, then write and read back words 0..3 at 0x00, 0x04, 0x08, 0x0C with 0x0101FFFF, 0xABCD0001, 0xDEAD0011, 0xBEEF0011, as concurrent AW and W with BREADY=RREADY=1 -> every BRESP and RRESP is 2'b00, each read returns the written data, ctrl_wr_strobe pulses 0001, 0010, 0100, 1000 in turn.
2. AW at cycle 0, W at cycle 3 to word 1 with data 0x12345678 and WSTRB=4'b0101, word 1 previously 0xABCD0001 -> AWREADY low in cycles 1-3, word 1 becomes 0xAB340078, BVALID appears the cycle after the W handshake.
3. Drive status_in word 5 = 0xCAFE0005, read 0x14 -> RDATA=0xCAFE0005 with OKAY. Write 0x14 -> BRESP=2'b10 and no ctrl change.
4. Hold RREADY low for 10 cycles after a read of word 2 -> RVALID and RDATA stay stable, ARREADY stays 0, and a concurrent write to word 0 completes normally.
5. Assert S_AXI_LITE_ARESET in W_WAIT with AW latched -> the next cycle has BVALID=0, ctrl_regs=C_CTRL_RESET and all READYs 0; after release, AWREADY=WREADY=ARREADY=1.
6. Same-edge read capture and write commit on word 3 (old value 0xBEEF0011, new 0x00000001) -> the read returns 0xBEEF0011 and a following read returns 0x00000001.
